// File: rtl/request_queue_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : request_queue_unit_if
// Description : Issue/memory handshake bundle for request_queue_unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface request_queue_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
);
    localparam int c_cnt_w = $clog2(DEPTH + 1);

    logic              ihit;
    logic              dhit;
    logic              halt;
    logic              flush;
    logic              issue_ren;
    logic              issue_wen;
    logic [ADDR_W-1:0] issue_addr;
    logic [DATA_W-1:0] issue_wdata;
    logic              iREN;
    logic              dREN;
    logic              dWEN;
    logic [ADDR_W-1:0] daddr;
    logic [DATA_W-1:0] dstore;
    logic              PCen;
    logic              full;
    logic              busy;
    logic [c_cnt_w-1:0] count;
    logic              timeout_err;

    // master: pipeline/cache side driving the issue and completion strobes
    modport master (
        output ihit, dhit, halt, flush, issue_ren, issue_wen, issue_addr, issue_wdata,
        input  iREN, dREN, dWEN, daddr, dstore, PCen, full, busy, count, timeout_err
    );

    modport slave (
        input  ihit, dhit, halt, flush, issue_ren, issue_wen, issue_addr, issue_wdata,
        output iREN, dREN, dWEN, daddr, dstore, PCen, full, busy, count, timeout_err
    );
endinterface
`default_nettype wire

// File: rtl/request_queue_unit.sv
`default_nettype none
// ============================================================================
// Module      : request_queue_unit
// Description : DEPTH-entry in-order data request queue with PC/fetch control.
// Revision    : 1.0 - initial release
// ============================================================================
module request_queue_unit #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 2,
    parameter int TIMEOUT = 0
) (
    input  logic                  CLK,
    input  logic                  nRst,
    request_queue_unit_if.slave   bus
);
    localparam int c_cnt_w = $clog2(DEPTH + 1);
    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

    logic [DEPTH-1:0]   r_ren;
    logic [DEPTH-1:0]   r_wen;
    logic [ADDR_W-1:0]  r_addr  [DEPTH];
    logic [DATA_W-1:0]  r_wdata [DEPTH];
    logic [c_ptr_w-1:0] r_head;
    logic [c_ptr_w-1:0] r_tail;
    logic [c_cnt_w-1:0] r_count;
    logic               r_iren;
    logic               r_halted;

    logic               w_busy;
    logic               w_full;
    logic               w_req;
    logic               w_pop;
    logic               w_push;
    logic [c_ptr_w-1:0] w_head_nxt;
    logic [c_ptr_w-1:0] w_tail_nxt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic               w_iren_nxt;

    function automatic logic [c_ptr_w-1:0] f_inc(input logic [c_ptr_w-1:0] p);
        if (DEPTH == 1 || p == c_ptr_w'(DEPTH - 1))
            return '0;
        else
            return p + 1'b1;
    endfunction

    assign w_busy = (r_count != '0);
    assign w_full = (r_count == c_depth);
    assign w_req  = bus.issue_ren | bus.issue_wen;
    assign w_pop  = bus.dhit & w_busy;
    // A full queue still accepts when the head retires on the same edge.
    assign w_push = bus.ihit & ~bus.halt & w_req & (~w_full | bus.dhit) & ~bus.flush;

    always_comb begin
        w_head_nxt = w_pop ? f_inc(r_head) : r_head;
        w_tail_nxt = r_tail;
        w_cnt_nxt  = r_count;
        if (bus.flush) begin
            // Only the in-flight head survives a flush, unless it retires now.
            w_cnt_nxt  = (w_busy && !w_pop) ? c_cnt_w'(1) : '0;
            w_tail_nxt = (w_cnt_nxt != '0) ? f_inc(w_head_nxt) : w_head_nxt;
        end else begin
            w_tail_nxt = w_push ? f_inc(r_tail) : r_tail;
            w_cnt_nxt  = r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
        end
        w_iren_nxt = ~(bus.halt | r_halted) & ~((w_cnt_nxt == c_depth) & ~bus.dhit);
    end

    always_ff @(posedge CLK or negedge nRst) begin
        if (!nRst) begin
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
            r_iren   <= 1'b1;
            r_halted <= 1'b0;
        end else begin
            r_head   <= w_head_nxt;
            r_tail   <= w_tail_nxt;
            r_count  <= w_cnt_nxt;
            r_iren   <= w_iren_nxt;
            r_halted <= r_halted | bus.halt;
        end
    end

    // Payload storage needs no reset: outputs are masked while empty.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_ren[r_tail]   <= bus.issue_ren & ~bus.issue_wen;
            r_wen[r_tail]   <= bus.issue_wen;
            r_addr[r_tail]  <= bus.issue_addr;
            r_wdata[r_tail] <= bus.issue_wdata;
        end
    end

    assign bus.iREN   = r_iren;
    assign bus.dREN   = w_busy & r_ren[r_head];
    assign bus.dWEN   = w_busy & r_wen[r_head];
    assign bus.daddr  = w_busy ? r_addr[r_head]  : '0;
    assign bus.dstore = w_busy ? r_wdata[r_head] : '0;
    assign bus.PCen   = bus.ihit & ~bus.halt & ~(w_full & ~bus.dhit & w_req);
    assign bus.full   = w_full;
    assign bus.busy   = w_busy;
    assign bus.count  = r_count;

    generate
        if (TIMEOUT > 0) begin : g_wdog
            localparam int c_wd_w = $clog2(TIMEOUT + 1);
            localparam logic [c_wd_w-1:0] c_timeout = c_wd_w'(TIMEOUT);

            logic [c_wd_w-1:0] r_wd_cnt;
            logic [c_wd_w-1:0] w_wd_nxt;
            logic              r_terr;

            always_comb begin
                w_wd_nxt = r_wd_cnt;
                if (w_pop || !w_busy)
                    w_wd_nxt = '0;
                else if (r_wd_cnt != c_timeout)
                    w_wd_nxt = r_wd_cnt + 1'b1;
            end

            always_ff @(posedge CLK or negedge nRst) begin
                if (!nRst) begin
                    r_wd_cnt <= '0;
                    r_terr   <= 1'b0;
                end else begin
                    r_wd_cnt <= w_wd_nxt;
                    r_terr   <= r_terr | (w_wd_nxt == c_timeout);
                end
            end

            assign bus.timeout_err = r_terr;
        end else begin : g_no_wdog
            assign bus.timeout_err = 1'b0;
        end
    endgenerate
endmodule
`default_nettype wire
